// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle for the sequential ALU.
// master = issuing stage (register-read side), slave = alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] input_1;
  logic [WIDTH-1:0] input_2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alu_op, input_1, input_2, out_ready,
    input  in_ready, out_valid, alu_out, zero, overflow
  );

  modport slave (
    input  in_valid, alu_op, input_1, input_2, out_ready,
    output in_ready, out_valid, alu_out, zero, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered single-cycle ops and iterative
// shift-add multiply / restoring divide. One op in flight at a time; issue
// stalls through in_ready while an op is busy or its result is unconsumed.
// Optional build macro: ALU_FAST_MUL_EN -- MUL becomes a combinational
// single-cycle op instead of the WIDTH-cycle shift-add sequence.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_SLL  = 4'd3,
    OP_SRL  = 4'd4,  OP_SRA  = 4'd5,  OP_SUB  = 4'd6,  OP_SLT  = 4'd7,
    OP_XOR  = 4'd8,  OP_MUL  = 4'd9,  OP_DIVU = 4'd10, OP_REMU = 4'd11,
    OP_NOR  = 4'd12, OP_SLTS = 4'd13, OP_RSV0 = 4'd14, OP_RSV1 = 4'd15
  } op_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  op_t                iter_op_q;
  logic [WIDTH-1:0]   op_a_q;     // MUL: multiplicand (shifts left); DIV: dividend/quotient
  logic [WIDTH-1:0]   op_b_q;     // MUL: multiplier (shifts right); DIV: divisor
  logic [WIDTH-1:0]   acc_q;      // MUL: partial product; DIV: partial remainder
  logic [WIDTH-1:0]   alu_out_q;
  logic               zero_q;
  logic               overflow_q;

  op_t                op;
  logic [WIDTH-1:0]   a, b;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_ovf;
  logic               is_iter;
  logic               accept;
  logic               last_step;

  logic [WIDTH-1:0]   mul_next;
  logic [WIDTH:0]     rem_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   iter_result;

  assign op     = op_t'(bus.alu_op);
  assign a      = bus.input_1;
  assign b      = bus.input_2;
  assign shamt  = b[SHAMT_W-1:0];
  assign sum    = a + b;
  assign diff   = a - b;

`ifdef ALU_FAST_MUL_EN
  assign is_iter = (op == OP_DIVU) || (op == OP_REMU);
`else
  assign is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`endif

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_step = (state_q == BUSY) && (cnt_q == CNT_W'(1));

  // Single-cycle result and signed-overflow flag from the live operands.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op)
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_SRA:  sc_result = $signed(a) >>> shamt;
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_result = WIDTH'(a < b);
      OP_XOR:  sc_result = a ^ b;
`ifdef ALU_FAST_MUL_EN
      OP_MUL:  sc_result = a * b;
`endif
      OP_NOR:  sc_result = ~(a | b);
      OP_SLTS: sc_result = WIDTH'($signed(a) < $signed(b));
      default: sc_result = '0;
    endcase
  end

  // One step of shift-add multiply and of restoring division.
  always_comb begin
    mul_next  = acc_q + (op_b_q[0] ? op_a_q : '0);
    rem_shift = {acc_q, op_a_q[WIDTH-1]};
    div_ge    = rem_shift >= {1'b0, op_b_q};
    rem_next  = div_ge ? WIDTH'(rem_shift - {1'b0, op_b_q}) : rem_shift[WIDTH-1:0];
    quo_next  = {op_a_q[WIDTH-2:0], div_ge};
    case (iter_op_q)
      OP_MUL:  iter_result = mul_next;
      OP_DIVU: iter_result = quo_next;
      OP_REMU: iter_result = rem_next;
      default: iter_result = '0;
    endcase
  end

  // Next-state logic for the IDLE/BUSY/DONE handshake sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = is_iter ? BUSY : DONE;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    // NOTE: reset clears the datapath registers as well, so an op aborted by
    // reset leaves no stale partial result behind.
    if (!rst_n) begin
      cnt_q      <= '0;
      iter_op_q  <= OP_AND;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (is_iter) begin
        cnt_q     <= CNT_W'(WIDTH);
        iter_op_q <= op;
        op_a_q    <= a;
        op_b_q    <= b;
        acc_q     <= '0;
      end else begin
        alu_out_q  <= sc_result;
        zero_q     <= (sc_result == '0);
        overflow_q <= sc_ovf;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (iter_op_q == OP_MUL) begin
        acc_q  <= mul_next;
        op_a_q <= op_a_q << 1;
        op_b_q <= op_b_q >> 1;
      end else begin
        acc_q  <= rem_next;
        op_a_q <= quo_next;
      end
      if (last_step) begin
        alu_out_q  <= iter_result;
        zero_q     <= (iter_result == '0);
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_out   = alu_out_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, self-checking bench for alu_seq (WIDTH = 32).
// Each scenario task drives its own vectors and compares inline against
// hand-computed values.
module tb_alu_seq;
  localparam int WIDTH = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();
  alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one op, wait for the accept edge, scramble the inputs, then count
  // cycles until out_valid (bounded). leak flags in_ready seen high meanwhile.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit leak);
    bus.alu_op   = op;
    bus.input_1  = a;
    bus.input_2  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'd2;
    bus.input_1  = ~a;
    bus.input_2  = ~b;
    lat  = 1;
    leak = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.in_ready !== 1'b0) leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.alu_out !== 32'h0) begin errors++; $display("FAIL reset alu_out: got %h expected 00000000", bus.alu_out); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset zero: got %b expected 0", bus.zero); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", bus.overflow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_arith;
    vec_t tbl[4] = '{
      '{4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
      '{4'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0},
      '{4'd6, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1},
      '{4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0}
    };
    int lat;
    bit leak;
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, leak);
      checks++; if (lat !== 1) begin errors++; $display("FAIL arith[%0d] latency: got %0d expected 1", i, lat); end
      checks++; if (bus.alu_out !== tbl[i].res) begin errors++; $display("FAIL arith[%0d] alu_out: got %h expected %h", i, bus.alu_out, tbl[i].res); end
      checks++; if (bus.zero !== tbl[i].z) begin errors++; $display("FAIL arith[%0d] zero: got %b expected %b", i, bus.zero, tbl[i].z); end
      checks++; if (bus.overflow !== tbl[i].ov) begin errors++; $display("FAIL arith[%0d] overflow: got %b expected %b", i, bus.overflow, tbl[i].ov); end
      release_result();
    end
  endtask

  task automatic test_logic_shift;
    vec_t tbl[11] = '{
      '{4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0},
      '{4'd1,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0},
      '{4'd8,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0},
      '{4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{4'd3,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0},
      '{4'd4,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0},
      '{4'd5,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0},
      '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
      '{4'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0},
      '{4'd14, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0},
      '{4'd15, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0}
    };
    int lat;
    bit leak;
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, leak);
      checks++; if (lat !== 1) begin errors++; $display("FAIL logic[%0d] latency: got %0d expected 1", i, lat); end
      checks++; if (bus.alu_out !== tbl[i].res) begin errors++; $display("FAIL logic[%0d] alu_out: got %h expected %h", i, bus.alu_out, tbl[i].res); end
      checks++; if (bus.zero !== tbl[i].z) begin errors++; $display("FAIL logic[%0d] zero: got %b expected %b", i, bus.zero, tbl[i].z); end
      checks++; if (bus.overflow !== tbl[i].ov) begin errors++; $display("FAIL logic[%0d] overflow: got %b expected %b", i, bus.overflow, tbl[i].ov); end
      release_result();
    end
  endtask

  task automatic test_mul;
    vec_t tbl[3] = '{
      '{4'd9, 32'd1000,       32'd1000,       32'h000F_4240, 1'b0, 1'b0},
      '{4'd9, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 1'b0},
      '{4'd9, 32'h1234_5678,  32'h0000_0000,  32'h0000_0000, 1'b1, 1'b0}
    };
    int lat;
    bit leak;
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, leak);
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul[%0d] latency: got %0d expected %0d", i, lat, MUL_LAT); end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL mul[%0d] in_ready while busy: got 1 expected 0", i); end
      checks++; if (bus.alu_out !== tbl[i].res) begin errors++; $display("FAIL mul[%0d] alu_out: got %h expected %h", i, bus.alu_out, tbl[i].res); end
      checks++; if (bus.zero !== tbl[i].z) begin errors++; $display("FAIL mul[%0d] zero: got %b expected %b", i, bus.zero, tbl[i].z); end
      release_result();
    end
  endtask

  task automatic test_div;
    vec_t tbl[6] = '{
      '{4'd10, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0},
      '{4'd11, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0},
      '{4'd10, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0},
      '{4'd11, 32'd100,       32'd0,         32'd100,       1'b0, 1'b0},
      '{4'd10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 1'b0},
      '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0}
    };
    int lat;
    bit leak;
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, leak);
      checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, DIV_LAT); end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL div[%0d] in_ready while busy: got 1 expected 0", i); end
      checks++; if (bus.alu_out !== tbl[i].res) begin errors++; $display("FAIL div[%0d] alu_out: got %h expected %h", i, bus.alu_out, tbl[i].res); end
      checks++; if (bus.zero !== tbl[i].z) begin errors++; $display("FAIL div[%0d] zero: got %b expected %b", i, bus.zero, tbl[i].z); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL div[%0d] overflow: got %b expected 0", i, bus.overflow); end
      release_result();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bit leak;
    issue(4'd2, 32'd3, 32'd4, lat, leak);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bp latency: got %0d expected 1", lat); end
    // A competing op presented while the result is held must be ignored.
    bus.alu_op   = 4'd2;
    bus.input_1  = 32'd100;
    bus.input_2  = 32'd100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d] out_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.alu_out !== 32'd7) begin errors++; $display("FAIL bp[%0d] alu_out: got %h expected 00000007", i, bus.alu_out); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d] in_ready: got %b expected 0", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    release_result();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp release out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    bit leak;
    bus.alu_op   = 4'd9;
    bus.input_1  = 32'd1000;
    bus.input_2  = 32'd1000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.alu_out !== 32'h0) begin errors++; $display("FAIL abort alu_out: got %h expected 00000000", bus.alu_out); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort in_ready: got %b expected 1", bus.in_ready); end
    // Stay in IDLE for a few cycles: the aborted op must not resurface.
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort stale out_valid: got %b expected 0", bus.out_valid); end
    issue(4'd2, 32'd1, 32'd1, lat, leak);
    checks++; if (lat !== 1) begin errors++; $display("FAIL post-abort latency: got %0d expected 1", lat); end
    checks++; if (bus.alu_out !== 32'd2) begin errors++; $display("FAIL post-abort alu_out: got %h expected 00000002", bus.alu_out); end
    release_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_op    = 4'd0;
    bus.input_1   = '0;
    bus.input_2   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Single-cycle logic, add and compare ops are registered. Adds shifts, XOR, signed compare, overflow, and iterative multiply/divide.
- Sits between register-read and writeback in the multi-cycle core. Stalls issue via ready/valid while an iterative op runs.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8
SHAMT_W, $clog2(WIDTH), localparam; shift-amount bits taken from input_2[SHAMT_W-1:0]

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept operation
alu_op  input  4  operation code
input_1  input  WIDTH  operand A
input_2  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
alu_out  output  WIDTH  registered result
zero  output  1  registered, (alu_out == 0)
overflow  output  1  registered signed overflow, ADD/SUB only, else 0

Behaviour:
- Opcodes, with A = input_1 and B = input_2:
  - 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA
  - 6 SUB, 7 SLT unsigned (A<B ? 1 : 0), 8 XOR, 9 MUL (low WIDTH bits)
  - 10 DIVU quotient, 11 REMU, 12 NOR, 13 SLTS signed
  - 14, 15 produce result 0 with single-cycle latency.
- Arithmetic is modulo 2^WIDTH. Shifts use B[SHAMT_W-1:0] only.
- Overflow:
  - ADD: A, B same sign and result sign differs.
  - SUB: A, B signs differ and result sign differs from A.
- Divide by zero: DIVU = all ones, REMU = A. No error flag.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE). out_valid = (state == DONE).
  - IDLE, in_valid high, single-cycle op: compute, register alu_out/zero/overflow, go DONE. out_valid is high in the cycle after acceptance (latency 1).
  - IDLE, in_valid high, op 9/10/11: latch operands, clear accumulator, load counter = WIDTH, go BUSY.
  - BUSY, MUL: shift-add, one multiplier bit per cycle.
  - BUSY, DIVU/REMU: restoring division, one quotient bit per cycle.
  - BUSY: counter decrements each cycle. At counter == 1, register the result and go DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE: alu_out, zero and overflow are held stable. On out_ready high, go IDLE. No back-to-back accept in the same cycle.
- Inputs are ignored while in_ready is low. Operands are sampled only on the accept edge; later changes to inputs do not affect an in-flight op.
- Reset (rst_n low at a clk edge): state IDLE, alu_out 0, zero 0, overflow 0, out_valid 0, counter 0, internal accumulators 0.
  - Reset asserted mid-BUSY or in DONE aborts the op and discards the result.
  - in_ready is 1 in the first cycle after rst_n rises.
- out_ready is ignored outside DONE.

Optional Feature:
ALU_FAST_MUL_EN
- Defined: MUL (9) uses a combinational WIDTH x WIDTH multiplier, low half. It is treated as a single-cycle op (latency 1, never enters BUSY).
- Undefined: iterative shift-add multiply with latency WIDTH+1.
- DIVU/REMU are iterative in both builds.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1: out_valid at accept+1, alu_out 0x80000000, overflow 1, zero 0. SUB 5 - 5: alu_out 0, zero 1, overflow 0.
- SRA 0x80000000 by B=0x24 (shamt 4): 0xF8000000. SLTS 0xFFFFFFFF vs 1: 1. SLT 0xFFFFFFFF vs 1: 0. Opcode 15: alu_out 0.
- MUL 1000 x 1000: alu_out 0x000F4240, out_valid exactly 33 cycles after accept, in_ready 0 throughout. With ALU_FAST_MUL_EN: 1 cycle.
- DIVU 100 / 7: 14. REMU 100 / 7: 2. DIVU 100 / 0: 0xFFFFFFFF. REMU 100 / 0: 100. Each takes 33 cycles.
- Backpressure: ADD 3 + 4 with out_ready held low 5 cycles: out_valid stays 1, alu_out stays 7, in_ready stays 0. out_ready high for 1 cycle: out_valid 0 and in_ready 1 next cycle.
- Reset mid-op: start MUL, drive rst_n low for 1 cycle at accept+10: next cycle out_valid 0, alu_out 0, in_ready 1. A new ADD 1 + 1 then returns 2 at latency 1.
